// File: rtl/mazecaster_pkg.sv
// Shared types and screen geometry for the ray-cast render path.
package mazecaster_pkg;

    localparam int SCREEN_WIDTH  = 320;
    localparam int SCREEN_HEIGHT = 180;
    localparam int FB_DEPTH      = SCREEN_WIDTH * SCREEN_HEIGHT;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_RENDER = 2'd2,
        ST_READY  = 2'd3
    } t_sched_state;

endpackage

// File: rtl/fb_write_port.sv
// Registered frame buffer write port: range check, bank offset and write strobe.
module fb_write_port
    import mazecaster_pkg::*;
#(
    parameter int PIXEL_WIDTH = 16,
    parameter int DEPTH       = FB_DEPTH,
    parameter int ADDR_WIDTH  = 17
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_n_in,
    input  logic                   active,
    input  logic                   bank,
    input  logic                   valid,
    input  logic [15:0]            address,
    input  logic [PIXEL_WIDTH-1:0] pixel,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [PIXEL_WIDTH-1:0] wr_data
);

    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    logic [ADDR_WIDTH-1:0] addr_ext;
    logic [ADDR_WIDTH-1:0] bank_offset;

    assign addr_ext    = {{(ADDR_WIDTH-16){1'b0}}, address};
    assign bank_offset = bank ? DEPTH_A : '0;

    // Address and data track the stream throughout a sweep; only the strobe is qualified.
    always_ff @(posedge pixel_clk_in) begin
        if (!rst_n_in) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (active) begin
            wr_en   <= valid && (addr_ext < DEPTH_A);
            wr_addr <= addr_ext + bank_offset;
            wr_data <= pixel;
        end else begin
            wr_en   <= 1'b0;
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// Frame-level sequencer: launches DDA sweeps on frame sync, forwards pixels into the
// render bank and swaps banks only at frame sync.
//
//  state  | meaning
//  IDLE   | no sweep in flight; waits for sync with enable
//  START  | one-cycle sweep launch pulse; watchdog loaded
//  RENDER | pixels written to render bank; watchdog running
//  READY  | sweep complete; waits for sync to swap banks
module frame_scheduler
    import mazecaster_pkg::*;
#(
    parameter int PIXEL_WIDTH     = 16,
    parameter int FB_DEPTH        = mazecaster_pkg::FB_DEPTH,
    parameter int ADDR_WIDTH      = 17,
    parameter int WATCHDOG_CYCLES = 1048576
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_n_in,
    input  logic                   enable_in,
    input  logic                   frame_sync_in,
    output logic                   sweep_start_out,
    input  logic                   ray_valid_in,
    input  logic [15:0]            ray_address_in,
    input  logic [PIXEL_WIDTH-1:0] ray_pixel_in,
    input  logic                   ray_last_pixel_in,
    output logic                   fb_wr_en_out,
    output logic [ADDR_WIDTH-1:0]  fb_wr_addr_out,
    output logic [PIXEL_WIDTH-1:0] fb_wr_data_out,
    output logic                   render_bank_out,
    output logic                   display_bank_out,
    output logic [15:0]            frame_count_out,
    output logic [7:0]             drop_count_out,
    output logic                   timeout_out
);

    localparam int WD_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WATCHDOG_CYCLES - 1);

    t_sched_state state, next_state;

    logic [WD_W-1:0] wd_count;
    logic            render_bank;
    logic            display_bank;
    logic [15:0]     frame_count;
    logic [7:0]      drop_count;
    logic            timeout;

    logic            last_pixel;
    logic            wd_expire;
    logic            swap;
    logic [1:0]      drop_inc;
    logic [8:0]      drop_sum;

    assign last_pixel = ray_valid_in && ray_last_pixel_in;
    // A last pixel arriving on the terminal watchdog cycle still completes the frame.
    assign wd_expire  = (state == ST_RENDER) && (wd_count == '0) && !last_pixel;
    assign swap       = (state == ST_READY) && frame_sync_in;
    assign drop_sum   = {1'b0, drop_count} + {7'b0, drop_inc};

    always_comb begin
        next_state = state;
        drop_inc   = 2'd0;
        case (state)
            ST_IDLE: begin
                if (frame_sync_in && enable_in) next_state = ST_START;
            end
            ST_START: begin
                next_state = ST_RENDER;
            end
            ST_RENDER: begin
                drop_inc = {1'b0, frame_sync_in} + {1'b0, wd_expire};
                if (last_pixel)     next_state = ST_READY;
                else if (wd_expire) next_state = ST_IDLE;
            end
            ST_READY: begin
                if (frame_sync_in) next_state = enable_in ? ST_START : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_n_in) begin
            state        <= ST_IDLE;
            wd_count     <= '0;
            render_bank  <= 1'b0;
            display_bank <= 1'b1;
            frame_count  <= '0;
            drop_count   <= '0;
            timeout      <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_START) begin
                wd_count <= WD_LOAD;
            end else if (state == ST_RENDER && wd_count != '0) begin
                wd_count <= wd_count - 1'b1;
            end
            if (swap) begin
                render_bank  <= ~render_bank;
                display_bank <= ~display_bank;
                frame_count  <= frame_count + 16'd1;
            end
            drop_count <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
            if (wd_expire) timeout <= 1'b1;
        end
    end

    fb_write_port #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .DEPTH       (FB_DEPTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_fb_write_port (
        .pixel_clk_in (pixel_clk_in),
        .rst_n_in     (rst_n_in),
        .active       (state == ST_RENDER),
        .bank         (render_bank),
        .valid        (ray_valid_in),
        .address      (ray_address_in),
        .pixel        (ray_pixel_in),
        .wr_en        (fb_wr_en_out),
        .wr_addr      (fb_wr_addr_out),
        .wr_data      (fb_wr_data_out)
    );

    assign sweep_start_out  = (state == ST_START);
    assign render_bank_out  = render_bank;
    assign display_bank_out = display_bank;
    assign frame_count_out  = frame_count;
    assign drop_count_out   = drop_count;
    assign timeout_out      = timeout;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: directed scenarios then random traffic against a frame-level model.
module tb_frame_scheduler;

    localparam int W     = 64;
    localparam int DEPTH = 57600;

    logic        pixel_clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        enable_in = 1'b0;
    logic        frame_sync_in = 1'b0;
    logic        sweep_start_out;
    logic        ray_valid_in = 1'b0;
    logic [15:0] ray_address_in = '0;
    logic [15:0] ray_pixel_in = '0;
    logic        ray_last_pixel_in = 1'b0;
    logic        fb_wr_en_out;
    logic [16:0] fb_wr_addr_out;
    logic [15:0] fb_wr_data_out;
    logic        render_bank_out;
    logic        display_bank_out;
    logic [15:0] frame_count_out;
    logic [7:0]  drop_count_out;
    logic        timeout_out;

    always #5 pixel_clk_in = ~pixel_clk_in;

    frame_scheduler #(
        .PIXEL_WIDTH     (16),
        .FB_DEPTH        (DEPTH),
        .ADDR_WIDTH      (17),
        .WATCHDOG_CYCLES (W)
    ) dut (
        .pixel_clk_in      (pixel_clk_in),
        .rst_n_in          (rst_n_in),
        .enable_in         (enable_in),
        .frame_sync_in     (frame_sync_in),
        .sweep_start_out   (sweep_start_out),
        .ray_valid_in      (ray_valid_in),
        .ray_address_in    (ray_address_in),
        .ray_pixel_in      (ray_pixel_in),
        .ray_last_pixel_in (ray_last_pixel_in),
        .fb_wr_en_out      (fb_wr_en_out),
        .fb_wr_addr_out    (fb_wr_addr_out),
        .fb_wr_data_out    (fb_wr_data_out),
        .render_bank_out   (render_bank_out),
        .display_bank_out  (display_bank_out),
        .frame_count_out   (frame_count_out),
        .drop_count_out    (drop_count_out),
        .timeout_out       (timeout_out)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Frame-level model: launching / sweeping / awaiting swap, plus cycles spent sweeping.
    bit m_launch, m_sweep, m_await, m_timeout, m_bank, m_wr_en;
    int m_cycles, m_frames, m_drops, m_wr_addr, m_wr_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit rst, en, sync, valid, input int addr, pix, input bit last);
        int inc;
        if (!rst) begin
            m_launch = 0; m_sweep = 0; m_await = 0; m_timeout = 0; m_bank = 0;
            m_cycles = 0; m_frames = 0; m_drops = 0;
            m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0;
        end else if (m_launch) begin
            m_launch = 0; m_sweep = 1; m_cycles = 0; m_wr_en = 0;
        end else if (m_sweep) begin
            m_wr_en   = valid && (addr < DEPTH);
            m_wr_addr = addr + (m_bank ? DEPTH : 0);
            m_wr_data = pix;
            inc = sync ? 1 : 0;
            if (valid && last) begin
                m_sweep = 0; m_await = 1;
            end else if (m_cycles == W - 1) begin
                m_sweep = 0; m_timeout = 1; inc++;
            end else begin
                m_cycles++;
            end
            m_drops = (m_drops + inc > 255) ? 255 : m_drops + inc;
        end else if (m_await) begin
            m_wr_en = 0;
            if (sync) begin
                m_bank   = !m_bank;
                m_frames = (m_frames + 1) % 65536;
                m_await  = 0;
                m_launch = en;
            end
        end else begin
            m_wr_en = 0;
            if (sync && en) m_launch = 1;
        end
    endtask

    task automatic compare_all();
        check("sweep_start", 32'(sweep_start_out), 32'(m_launch));
        check("wr_en", 32'(fb_wr_en_out), 32'(m_wr_en));
        check("wr_addr", 32'(fb_wr_addr_out), 32'(m_wr_addr));
        check("wr_data", 32'(fb_wr_data_out), 32'(m_wr_data));
        check("render_bank", 32'(render_bank_out), 32'(m_bank));
        check("display_bank", 32'(display_bank_out), 32'(!m_bank));
        check("frame_count", 32'(frame_count_out), 32'(m_frames));
        check("drop_count", 32'(drop_count_out), 32'(m_drops));
        check("timeout", 32'(timeout_out), 32'(m_timeout));
    endtask

    task automatic step(input bit rst, en, sync, valid, input int addr, pix, input bit last);
        rst_n_in          = rst;
        enable_in         = en;
        frame_sync_in     = sync;
        ray_valid_in      = valid;
        ray_address_in    = 16'(addr);
        ray_pixel_in      = 16'(pix);
        ray_last_pixel_in = last;
        @(posedge pixel_clk_in);
        model(rst, en, sync, valid, addr, pix, last);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input bit en);
        for (int i = 0; i < n; i++) step(1, en, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // reset and first launch (bank 0)
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 5, 5, 0);
        step(1, 1, 1, 0, 0, 0, 0);
        idle(2, 1);
        step(1, 1, 0, 1, 100, 16'h1234, 0);
        step(1, 1, 0, 1, 57600, 16'h2222, 0);
        step(1, 1, 0, 1, 57599, 16'hBEEF, 1);
        idle(3, 1);
        step(1, 1, 1, 0, 0, 0, 0);
        idle(1, 1);
        // bank 1 sweep with two dropped syncs
        step(1, 1, 0, 1, 100, 16'h0A0A, 0);
        step(1, 1, 1, 1, 65535, 16'h0B0B, 0);
        step(1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 16'h0C0C, 1);
        idle(2, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        idle(2, 0);
        // watchdog abort
        step(1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < W + 4; i++)
            step(1, 1, 0, i % 2, i * 7, i, 0);
        // last pixel on the terminal watchdog cycle wins
        step(1, 1, 1, 0, 0, 0, 0);
        idle(1, 1);
        for (int i = 0; i < W - 1; i++) step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 42, 16'h4242, 1);
        idle(2, 1);
        step(1, 1, 1, 0, 0, 0, 0);
        idle(2, 1);
        // reset mid-render while writing
        step(1, 1, 0, 1, 300, 16'h3030, 0);
        step(0, 1, 0, 1, 301, 16'h3131, 0);
        idle(2, 1);
        // continuous sync drives drop_count into saturation
        for (int i = 0; i < 400; i++) step(1, 1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            bit rst, en, sync, valid, last;
            int addr;
            rst   = ($urandom_range(0, 599) != 0);
            en    = ($urandom_range(0, 9) != 0);
            sync  = ($urandom_range(0, 39) == 0);
            valid = ($urandom_range(0, 1) == 1);
            last  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) != 0) addr = $urandom_range(0, DEPTH - 1);
            else                           addr = $urandom_range(DEPTH - 4, 65535);
            step(rst, en, sync, valid, addr, $urandom_range(0, 65535), last);
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
